// File: rtl/ifid_hazard_ctrl_if.sv
// Control-plane bundle between the fetch/decode pipeline and its hazard controller.
// The pipeline side drives hazard inputs; the controller drives enables and status.
interface ifid_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      IDEX_MemRead;
    logic [REG_ADDR_WIDTH-1:0] IDEX_Rt;
    logic [REG_ADDR_WIDTH-1:0] IFID_Rs;
    logic [REG_ADDR_WIDTH-1:0] IFID_Rt;
    logic                      Branch_taken;
    logic                      Jump;
    logic                      imem_ready;

    logic                      PCWrite;
    logic                      Write_IFID;
    logic                      Flush_IFID;
    logic                      Bubble_IDEX;
    logic                      timeout_err;
    logic [CNT_WIDTH-1:0]      stall_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, Branch_taken, Jump, imem_ready,
        input  PCWrite, Write_IFID, Flush_IFID, Bubble_IDEX, timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, Branch_taken, Jump, imem_ready,
        output PCWrite, Write_IFID, Flush_IFID, Bubble_IDEX, timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID + PC sequencing: load-use stall, branch/jump flush, imem wait with watchdog, perf counters.
// Latency: control outputs are combinational (same cycle); state/counters update on negedge clk.
// Backpressure: imem not ready or load-use holds PC and IF/ID and injects an ID/EX bubble.
module ifid_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16,
    parameter int MAX_WAIT       = 15
) (
    input  logic               clk,
    input  logic               rst,
    ifid_hazard_ctrl_if.slave  hz
);
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 err_q;
    logic                 err_set;
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] flush_q;
    logic                 stall_inc;
    logic                 flush_inc;

    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic                      flush;
    logic                      lu;

    logic pc_we, ifid_we, ifid_fl, idex_bub;

    assign ex_rt = hz.IDEX_Rt;
    assign id_rs = hz.IFID_Rs;
    assign id_rt = hz.IFID_Rt;

    assign flush = hz.Branch_taken | hz.Jump;
    // r0 is hardwired zero, so a load targeting it never creates a real dependency
    assign lu    = hz.IDEX_MemRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        ifid_fl   = 1'b0;
        idex_bub  = 1'b0;
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        err_set   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (rst) begin
            case (state_q)
                ERROR: begin
                    idex_bub = 1'b1;
                end
                default: begin
                    if (flush) begin
                        // redirect wins even over a missing fetch; the new fetch is judged next cycle
                        pc_we     = 1'b1;
                        ifid_fl   = 1'b1;
                        idex_bub  = 1'b1;
                        flush_inc = 1'b1;
                        wcnt_d    = '0;
                        state_d   = RUN;
                    end else if (!hz.imem_ready) begin
                        idex_bub  = 1'b1;
                        stall_inc = 1'b1;
                        wcnt_d    = wcnt_q + 1'b1;
                        if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                            state_d = ERROR;
                            err_set = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else if (lu) begin
                        idex_bub  = 1'b1;
                        stall_inc = 1'b1;
                        wcnt_d    = '0;
                        state_d   = RUN;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        wcnt_d  = '0;
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign hz.PCWrite     = pc_we;
    assign hz.Write_IFID  = ifid_we;
    assign hz.Flush_IFID  = ifid_fl;
    assign hz.Bubble_IDEX = idex_bub;
    assign hz.timeout_err = err_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
endmodule
